// File: rtl/sn_req_arbiter_pkg.sv
// sn_req_arbiter_pkg: node request/response types, opcodes and FSM encodings
// shared by the SN request arbiter and its per-RN slots.
`default_nettype none

package sn_req_arbiter_pkg;

    localparam int OP_W   = 4;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    typedef logic [OP_W-1:0] OpType;

    localparam OpType op_read  = 4'h1;
    localparam OpType op_write = 4'h2;
    localparam OpType op_error = 4'hF;

    typedef struct packed {
        OpType             opcode;
        logic [ADDR_W-1:0] addr;
    } ReqType;

    typedef struct packed {
        OpType             opcode;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } DataType;

    typedef enum logic [1:0] {
        SLOT_EMPTY   = 2'd0,
        SLOT_ARMED   = 2'd1,
        SLOT_PENDING = 2'd2
    } SlotStateType;

    typedef enum logic [2:0] {
        ARB_IDLE     = 3'd0,
        ARB_REQ_PRE  = 3'd1,
        ARB_REQ_SEND = 3'd2,
        ARB_WAIT     = 3'd3,
        ARB_RSP_PRE  = 3'd4,
        ARB_RSP_SEND = 3'd5
    } ArbStateType;

endpackage

`default_nettype wire

// File: rtl/rn_req_slot.sv
// rn_req_slot: one RN request slot; arms on pre, captures the payload on valid,
// holds it PENDING until the response for this RN has been delivered.
`default_nettype none

module rn_req_slot
    import sn_req_arbiter_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   pre,
    input  logic   valid,
    input  ReqType req_in,
    input  logic   done,
    output logic   busy,
    output ReqType req
);

    SlotStateType state;
    SlotStateType state_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SLOT_EMPTY;
            busy  <= 1'b0;
            req   <= '0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == SLOT_PENDING);
            if (state == SLOT_ARMED && valid) begin
                req <= req_in;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SLOT_EMPTY:   if (pre)   state_nxt = SLOT_ARMED;
            SLOT_ARMED:   if (valid) state_nxt = SLOT_PENDING;
            SLOT_PENDING: if (done)  state_nxt = SLOT_EMPTY;
            default:                 state_nxt = SLOT_EMPTY;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/sn_req_arbiter.sv
// sn_req_arbiter: round-robin sharing of one SN among NUM_RN RNs, one SN
// transaction outstanding, with a response timeout for a silent SN.
`default_nettype none

module sn_req_arbiter
    import sn_req_arbiter_pkg::*;
#(
    parameter int NUM_RN         = 4,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_RN-1:0]   rn_pre_rx_req,
    input  ReqType [NUM_RN-1:0] rn_rx_req,
    input  logic [NUM_RN-1:0]   rn_v_rx_req,
    output logic [NUM_RN-1:0]   rn_busy,
    output logic [NUM_RN-1:0]   rn_pre_tx_data,
    output DataType             rn_tx_data,
    output logic [NUM_RN-1:0]   rn_v_tx_data,
    output logic                sn_pre_tx_req,
    output ReqType              sn_tx_req,
    output logic                sn_v_tx_req,
    input  logic                sn_pre_rx_data,
    input  DataType             sn_rx_data,
    input  logic                sn_v_rx_data,
    output logic                err_timeout,
    output logic                err_unexpected
);

    localparam int IDX_W = $clog2(NUM_RN);
    localparam int SUM_W = IDX_W + 1;

    ArbStateType         state;
    ArbStateType         state_nxt;
    logic [IDX_W-1:0]    owner;
    logic [IDX_W-1:0]    ptr;
    logic [IDX_W-1:0]    grant_idx;
    logic                grant_found;
    logic [SUM_W-1:0]    idx_sum;
    logic [CNT_W-1:0]    cnt;
    DataType             rsp;
    ReqType [NUM_RN-1:0] slot_req;
    logic                in_wait;
    logic                timeout_hit;
    logic                nxt_sn_pre;
    logic                nxt_sn_v;
    logic [NUM_RN-1:0]   nxt_rn_pre;
    logic [NUM_RN-1:0]   nxt_rn_v;
    logic                sn_pre_unused;

    assign sn_pre_unused = sn_pre_rx_data;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RN; gi++) begin : g_slot
            rn_req_slot u_slot (
                .clk    (clk),
                .reset  (reset),
                .pre    (rn_pre_rx_req[gi]),
                .valid  (rn_v_rx_req[gi]),
                .req_in (rn_rx_req[gi]),
                .done   (rn_v_tx_data[gi]),
                .busy   (rn_busy[gi]),
                .req    (slot_req[gi])
            );
        end
    endgenerate

    // Scan downward so the pending slot closest above the pointer wins last.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        idx_sum     = '0;
        for (int i = NUM_RN - 1; i >= 0; i--) begin
            idx_sum = {1'b0, ptr} + SUM_W'(i);
            if (idx_sum >= SUM_W'(NUM_RN)) begin
                idx_sum = idx_sum - SUM_W'(NUM_RN);
            end
            if (rn_busy[idx_sum[IDX_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = idx_sum[IDX_W-1:0];
            end
        end
    end

    assign in_wait     = (state == ARB_WAIT);
    assign timeout_hit = in_wait && !sn_v_rx_data && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ARB_IDLE;
            owner          <= '0;
            ptr            <= '0;
            cnt            <= '0;
            rsp            <= '0;
            sn_tx_req      <= '0;
            sn_pre_tx_req  <= 1'b0;
            sn_v_tx_req    <= 1'b0;
            rn_pre_tx_data <= '0;
            rn_v_tx_data   <= '0;
            err_timeout    <= 1'b0;
            err_unexpected <= 1'b0;
        end else begin
            state          <= state_nxt;
            sn_pre_tx_req  <= nxt_sn_pre;
            sn_v_tx_req    <= nxt_sn_v;
            rn_pre_tx_data <= nxt_rn_pre;
            rn_v_tx_data   <= nxt_rn_v;
            err_timeout    <= timeout_hit;
            err_unexpected <= sn_v_rx_data && !in_wait;
            if (state == ARB_IDLE && grant_found) begin
                owner <= grant_idx;
                ptr   <= (grant_idx == IDX_W'(NUM_RN - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (state == ARB_REQ_PRE) begin
                sn_tx_req <= slot_req[owner];
            end
            if (state == ARB_REQ_SEND) begin
                cnt <= '0;
            end else if (in_wait) begin
                cnt <= cnt + 1'b1;
            end
            if (in_wait && sn_v_rx_data) begin
                rsp <= sn_rx_data;
            end else if (timeout_hit) begin
                rsp <= '{opcode: op_error, addr: slot_req[owner].addr, data: '0};
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:     if (grant_found) state_nxt = ARB_REQ_PRE;
            ARB_REQ_PRE:  state_nxt = ARB_REQ_SEND;
            ARB_REQ_SEND: state_nxt = ARB_WAIT;
            ARB_WAIT:     if (sn_v_rx_data || timeout_hit) state_nxt = ARB_RSP_PRE;
            ARB_RSP_PRE:  state_nxt = ARB_RSP_SEND;
            ARB_RSP_SEND: state_nxt = ARB_IDLE;
            default:      state_nxt = ARB_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        nxt_sn_pre = (state_nxt == ARB_REQ_PRE);
        nxt_sn_v   = (state_nxt == ARB_REQ_SEND);
        nxt_rn_pre = '0;
        nxt_rn_v   = '0;
        if (state_nxt == ARB_RSP_PRE)  nxt_rn_pre[owner] = 1'b1;
        if (state_nxt == ARB_RSP_SEND) nxt_rn_v[owner]   = 1'b1;
    end

    assign rn_tx_data = rsp;

endmodule

`default_nettype wire

// File: tb/tb_sn_req_arbiter.sv
// tb_sn_req_arbiter: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-timeline model of the arbiter.
`default_nettype none

module tb_sn_req_arbiter;
    import sn_req_arbiter_pkg::*;

    localparam int N   = 4;
    localparam int TMO = 255;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  rn_pre_rx_req = '0;
    ReqType [N-1:0] rn_rx_req = '0;
    logic [N-1:0]  rn_v_rx_req = '0;
    logic [N-1:0]  rn_busy;
    logic [N-1:0]  rn_pre_tx_data;
    DataType       rn_tx_data;
    logic [N-1:0]  rn_v_tx_data;
    logic          sn_pre_tx_req;
    ReqType        sn_tx_req;
    logic          sn_v_tx_req;
    logic          sn_pre_rx_data = 1'b0;
    DataType       sn_rx_data = '0;
    logic          sn_v_rx_data = 1'b0;
    logic          err_timeout;
    logic          err_unexpected;

    sn_req_arbiter #(.NUM_RN(N), .TIMEOUT_CYCLES(TMO)) dut (
        .clk            (clk),
        .reset          (reset),
        .rn_pre_rx_req  (rn_pre_rx_req),
        .rn_rx_req      (rn_rx_req),
        .rn_v_rx_req    (rn_v_rx_req),
        .rn_busy        (rn_busy),
        .rn_pre_tx_data (rn_pre_tx_data),
        .rn_tx_data     (rn_tx_data),
        .rn_v_tx_data   (rn_v_tx_data),
        .sn_pre_tx_req  (sn_pre_tx_req),
        .sn_tx_req      (sn_tx_req),
        .sn_v_tx_req    (sn_v_tx_req),
        .sn_pre_rx_data (sn_pre_rx_data),
        .sn_rx_data     (sn_rx_data),
        .sn_v_rx_data   (sn_v_rx_data),
        .err_timeout    (err_timeout),
        .err_unexpected (err_unexpected)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: each transaction is a timeline anchored at its grant cycle g and
    // its response cycle r; slot contents follow the RN-side rules.
    int      cyc = 0;
    bit      m_act, m_resp, m_tmo, m_unexp;
    int      m_g, m_r, m_owner, m_ptr;
    ReqType  m_greq;
    DataType m_rsp;
    int      m_slot[N];
    ReqType  m_sreq[N];
    ReqType  got[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_act = 0; m_resp = 0; m_tmo = 0; m_unexp = 0;
        m_g = 0; m_r = 0; m_owner = 0; m_ptr = 0;
        m_greq = '0; m_rsp = '0;
        for (int i = 0; i < N; i++) begin
            m_slot[i] = 0;
            m_sreq[i] = '0;
        end
    endtask

    task automatic compare();
        logic [N-1:0] e_busy, e_rpre, e_rv;
        bit e_spre, e_sv, e_to;
        e_spre = m_act && (cyc == m_g + 1);
        e_sv   = m_act && (cyc == m_g + 2);
        e_rpre = '0;
        e_rv   = '0;
        if (m_act && m_resp && cyc == m_r + 1) e_rpre[m_owner] = 1'b1;
        if (m_act && m_resp && cyc == m_r + 2) e_rv[m_owner] = 1'b1;
        e_to = m_act && m_resp && m_tmo && (cyc == m_r + 1);
        for (int i = 0; i < N; i++) e_busy[i] = (m_slot[i] == 2);
        chk("sn_pre_tx_req", sn_pre_tx_req, e_spre);
        chk("sn_v_tx_req", sn_v_tx_req, e_sv);
        chk("rn_pre_tx_data", rn_pre_tx_data, e_rpre);
        chk("rn_v_tx_data", rn_v_tx_data, e_rv);
        chk("rn_busy", rn_busy, e_busy);
        chk("err_timeout", err_timeout, e_to);
        chk("err_unexpected", err_unexpected, m_unexp);
        if (e_sv) chk("sn_tx_req", sn_tx_req, m_greq);
        if (e_rv != '0) chk("rn_tx_data", rn_tx_data, m_rsp);
        if (reset) begin
            chk("reset_sn_tx_req", sn_tx_req, 0);
            chk("reset_rn_tx_data", rn_tx_data, 0);
        end
    endtask

    task automatic model_step();
        bit waiting, done, granted;
        waiting = m_act && !m_resp && (cyc >= m_g + 3);
        done    = m_act && m_resp && (cyc == m_r + 2);
        m_unexp = sn_v_rx_data && !waiting;
        if (waiting) begin
            if (sn_v_rx_data) begin
                m_resp = 1; m_r = cyc; m_rsp = sn_rx_data; m_tmo = 0;
            end else if (cyc - (m_g + 3) == TMO - 1) begin
                m_resp = 1; m_r = cyc; m_tmo = 1;
                m_rsp = '{opcode: op_error, addr: m_greq.addr, data: 32'h0};
            end
        end
        granted = 0;
        if (!m_act) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (!granted && m_slot[j] == 2) begin
                    granted = 1; m_owner = j; m_ptr = (j + 1) % N;
                    m_act = 1; m_resp = 0; m_tmo = 0; m_g = cyc; m_greq = m_sreq[j];
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (done && i == m_owner) m_slot[i] = 0;
            else if (m_slot[i] == 0 && rn_pre_rx_req[i]) m_slot[i] = 1;
            else if (m_slot[i] == 1 && rn_v_rx_req[i]) begin
                m_slot[i] = 2;
                m_sreq[i] = rn_rx_req[i];
            end
        end
        if (done) m_act = 0;
        cyc++;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (reset) model_reset();
            compare();
            if (!reset) model_step();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic issue(input logic [N-1:0] mask, input int base_addr);
        rn_pre_rx_req = mask;
        tick();
        rn_pre_rx_req = '0;
        for (int i = 0; i < N; i++) rn_rx_req[i] = '{opcode: op_read, addr: 16'(base_addr + i)};
        rn_v_rx_req = mask;
        tick();
        rn_v_rx_req = '0;
    endtask

    // SN that answers two cycles after each request valid; records grant order.
    task automatic serve(input int n);
        int due;
        int c;
        ReqType last;
        due = 0; c = 0; last = '0;
        got.delete();
        while (c < 200 && !(got.size() == n && rn_busy == '0)) begin
            sn_v_rx_data = 1'b0;
            if (due > 0) begin
                due--;
                if (due == 0) begin
                    sn_v_rx_data = 1'b1;
                    sn_rx_data = '{opcode: op_read, addr: last.addr, data: 32'(last.addr) + 32'h100};
                end
            end
            if (sn_v_tx_req) begin
                got.push_back(sn_tx_req);
                last = sn_tx_req;
                due = 2;
            end
            tick();
            c++;
        end
        sn_v_rx_data = 1'b0;
    endtask

    initial begin
        logic [63:0] rnd;
        int c_sv, c_to;
        bit got_v;

        do_reset();

        // RN1 read addr 5, SN answers 0x5 two cycles after its request valid.
        rn_pre_rx_req[1] = 1'b1;
        tick();
        rn_pre_rx_req = '0;
        rn_v_rx_req[1] = 1'b1;
        rn_rx_req[1] = '{opcode: op_read, addr: 16'd5};
        tick();
        rn_v_rx_req = '0;
        chk("t1_busy_pending", rn_busy[1], 1);
        tick();
        chk("t1_sn_pre", sn_pre_tx_req, 1);
        tick();
        chk("t1_sn_v", sn_v_tx_req, 1);
        chk("t1_sn_addr", sn_tx_req.addr, 5);
        tick();
        tick();
        sn_v_rx_data = 1'b1;
        sn_rx_data = '{opcode: op_read, addr: 16'd5, data: 32'h5};
        tick();
        sn_v_rx_data = 1'b0;
        chk("t1_rn_pre", rn_pre_tx_data, 4'b0010);
        tick();
        chk("t1_rn_v", rn_v_tx_data, 4'b0010);
        chk("t1_rn_data", rn_tx_data.data, 5);
        chk("t1_busy_held", rn_busy[1], 1);
        tick();
        chk("t1_busy_free", rn_busy[1], 0);

        // All four at once from pointer 0, then RN0 and RN2 again.
        do_reset();
        issue(4'b1111, 10);
        serve(4);
        chk("t2_count", got.size(), 4);
        for (int i = 0; i < got.size(); i++) chk($sformatf("t2_order%0d", i), got[i].addr, 10 + i);
        issue(4'b0101, 20);
        serve(2);
        chk("t2b_count", got.size(), 2);
        if (got.size() == 2) begin
            chk("t2b_first", got[0].addr, 20);
            chk("t2b_second", got[1].addr, 22);
        end

        // Silent SN after RN2 addr 7.
        issue(4'b0100, 5);
        c_sv = -1; c_to = -1; got_v = 0;
        for (int c = 0; c < 400 && !got_v; c++) begin
            if (sn_v_tx_req) c_sv = c;
            if (err_timeout) begin
                c_to = c;
                chk("t3_rn_pre", rn_pre_tx_data, 4'b0100);
            end
            if (rn_v_tx_data != '0) begin
                got_v = 1;
                chk("t3_rn_v", rn_v_tx_data, 4'b0100);
                chk("t3_rn_data", rn_tx_data, {op_error, 16'd7, 32'h0});
            end
            if (!got_v) tick();
        end
        chk("t3_timeout_delay", c_to - c_sv, 256);
        chk("t3_got_rsp", got_v, 1);
        repeat (3) tick();

        // SN data while idle.
        sn_v_rx_data = 1'b1;
        sn_rx_data = '{opcode: op_read, addr: 16'h1234, data: 32'hdead};
        tick();
        sn_v_rx_data = 1'b0;
        chk("t4_unexpected", err_unexpected, 1);
        chk("t4_no_rn_v", rn_v_tx_data, 0);
        tick();
        chk("t4_unexpected_pulse", err_unexpected, 0);
        chk("t4_still_idle", sn_pre_tx_req, 0);

        // Valid without pre on RN3.
        rn_v_rx_req[3] = 1'b1;
        rn_rx_req[3] = '{opcode: op_write, addr: 16'd3};
        tick();
        rn_v_rx_req = '0;
        for (int c = 0; c < 5; c++) begin
            chk("t5_busy3", rn_busy[3], 0);
            chk("t5_no_sn", {sn_pre_tx_req, sn_v_tx_req}, 0);
            tick();
        end

        // Reset in WAIT, then a late SN response.
        issue(4'b0001, 9);
        for (int c = 0; c < 20 && !sn_v_tx_req; c++) tick();
        chk("t6_sn_v_seen", sn_v_tx_req, 1);
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("t6_outputs_zero", {rn_busy, rn_pre_tx_data, rn_v_tx_data, sn_pre_tx_req,
                                sn_v_tx_req, err_timeout, err_unexpected}, 0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        sn_v_rx_data = 1'b1;
        tick();
        sn_v_rx_data = 1'b0;
        chk("t6_unexpected", err_unexpected, 1);
        chk("t6_no_rn_v", rn_v_tx_data, 0);

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++) begin
                rn_pre_rx_req[i] = ($urandom_range(3) == 0);
                rn_v_rx_req[i]   = ($urandom_range(2) == 0);
                rnd = {$urandom, $urandom};
                rn_rx_req[i] = rnd[$bits(ReqType)-1:0];
            end
            rnd = {$urandom, $urandom};
            sn_rx_data     = rnd[$bits(DataType)-1:0];
            sn_v_rx_data   = ($urandom_range(5) == 0);
            sn_pre_rx_data = 1'($urandom_range(1));
            tick();
        end
        rn_pre_rx_req = '0;
        rn_v_rx_req = '0;
        sn_v_rx_data = 1'b0;
        sn_pre_rx_data = 1'b0;
        repeat (300) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sn_req_arbiter.md
Name: sn_req_arbiter

Overview:
- Shares one subordinate node (SN) among NUM_RN requesting nodes (RNs).
- Captures one request per RN into a per-port slot and picks one slot round-robin.
- Replays the chosen request on the SN request channel using the pre/valid handshake, then routes the SN data response back to the owning RN.
- One SN transaction is outstanding at a time. A response timeout covers a silent SN.

Parameters:
- NUM_RN, 4, number of requesting nodes (2..8).
- TIMEOUT_CYCLES, 255, maximum cycles spent in WAIT before an error response is generated.
- CNT_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- rn_pre_rx_req  in  NUM_RN  per-RN request pre-announce
- rn_rx_req  in  NUM_RN x ReqType  per-RN request payload (opcode, addr)
- rn_v_rx_req  in  NUM_RN  per-RN request valid
- rn_busy  out  NUM_RN  slot occupied; the RN must not issue while high
- rn_pre_tx_data  out  NUM_RN  per-RN response pre-announce
- rn_tx_data  out  DataType  response payload, shared by all RNs and meaningful only with a valid bit
- rn_v_tx_data  out  NUM_RN  per-RN response valid
- sn_pre_tx_req  out  1  SN request pre-announce
- sn_tx_req  out  ReqType  SN request payload
- sn_v_tx_req  out  1  SN request valid
- sn_pre_rx_data  in  1  SN response pre-announce (informational only)
- sn_rx_data  in  DataType  SN response payload
- sn_v_rx_data  in  1  SN response valid
- err_timeout  out  1  one-cycle pulse when a timeout fires
- err_unexpected  out  1  one-cycle pulse when SN data arrives outside WAIT

Behaviour:
- Reset: all outputs 0, all slots EMPTY, arbiter in IDLE, round-robin pointer 0, timeout counter 0. Payload registers are 0.
- Reset asserted mid-transaction aborts it. No response is delivered and no error is pulsed.
- All outputs are registered.
- Slot FSM, one per RN (EMPTY, ARMED, PENDING):
  - EMPTY -> ARMED on rn_pre_rx_req.
  - ARMED -> PENDING on rn_v_rx_req; the payload is captured in that cycle.
  - PENDING -> EMPTY in the cycle after the RN's response valid.
  - rn_v_rx_req in EMPTY is ignored. rn_pre_rx_req in ARMED or PENDING is ignored.
  - rn_busy = slot is PENDING.
- Arbiter FSM (IDLE, REQ_PRE, REQ_SEND, WAIT, RSP_PRE, RSP_SEND):
  - IDLE: if any slot is PENDING, grant the first PENDING index found searching upward from the pointer, with wrap. Record the owner, set pointer = (owner+1) mod NUM_RN, go to REQ_PRE.
  - REQ_PRE: sn_pre_tx_req=1 for exactly one cycle, then REQ_SEND.
  - REQ_SEND: sn_v_tx_req=1 for exactly one cycle with the owner's payload, counter cleared, then WAIT.
  - WAIT: on sn_v_rx_data, capture sn_rx_data and go to RSP_PRE.
  - WAIT, no data: counter increments each cycle. When counter == TIMEOUT_CYCLES-1 and no data arrives, capture {op_error, owner's addr, data 0}, pulse err_timeout, go to RSP_PRE.
  - RSP_PRE: rn_pre_tx_data[owner]=1 for one cycle, then RSP_SEND.
  - RSP_SEND: rn_v_tx_data[owner]=1 for one cycle with rn_tx_data = captured response, then IDLE.
- Latency:
  - rn_v_rx_req at cycle t with the arbiter idle gives PENDING at t+1, grant at t+1, sn_pre_tx_req at t+2, sn_v_tx_req at t+3.
  - sn_v_rx_data at cycle r gives rn_pre_tx_data at r+1, rn_v_tx_data at r+2, rn_busy low at r+3.
- sn_v_rx_data outside WAIT: data dropped, err_unexpected pulsed, no state change.
- sn_v_rx_data in the same cycle as the timeout: the data wins and no error is raised.
- A slot may capture a new request in the same cycle the arbiter grants another slot.
- At most one rn_pre_tx_data / rn_v_tx_data bit is high at any time.

Decomposition:
- node_package additions:
  - SlotStateType (EMPTY, ARMED, PENDING)
  - ArbStateType (the six arbiter states)
  - op_error opcode constant
- Existing ReqType, DataType and op_* constants are reused.
- Sub-module rn_req_slot: one slot FSM plus payload register, instantiated NUM_RN times.

Test Plan:
- RN1 read addr 5; SN returns data 0x5 two cycles after request valid -> SN sees pre at t+2 and valid at t+3 with addr 5; rn_v_tx_data[1] pulses with data 0x5; rn_busy[1] falls 3 cycles after SN valid.
- RN0..RN3 all request in the same cycle, pointer 0 -> SN order 0,1,2,3; then RN0 and RN2 request again -> order 0,2.
- SN silent after a request from RN2, addr 7 -> err_timeout pulses after 255 WAIT cycles; RN2 receives op_error, addr 7, data 0.
- sn_v_rx_data pulsed while the arbiter is IDLE -> err_unexpected one cycle, no RN valid, state stays IDLE.
- rn_v_rx_req without a preceding pre on RN3 -> ignored, rn_busy[3] stays 0, no SN activity.
- Reset asserted during WAIT -> all outputs 0 immediately; a later SN response pulses err_unexpected.
